// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// One conversion in flight, valid/ready on both sides, flags digits above 9.
module bcd_to_bin_seq #(
   parameter int NDIG = 2,
   parameter int WOUT = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4*NDIG-1:0] bcd_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WOUT-1:0]   bin_out,
   output logic              err,
   output logic              busy
);

   localparam int CW = $clog2(WOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(WOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t            state;
   logic [4*NDIG-1:0] bcd_r;
   logic [WOUT-1:0]   bin_r;
   logic [CW-1:0]     cnt;

   logic              bad_digit;
   logic [4*NDIG-1:0] bcd_sh;
   logic [4*NDIG-1:0] bcd_nx;
   logic [WOUT-1:0]   bin_sh;

   // A digit is out of range when it is 10..15: bit 3 set plus bit 2 or bit 1.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if (bcd_in[4*i+3] & (bcd_in[4*i+2] | bcd_in[4*i+1]))
            bad_digit = 1'b1;
      end
   end

   // One iteration: shift {bcd_r, bin_r} right, then correct each digit >= 8 by -3.
   always_comb begin
      bcd_sh = bcd_r >> 1;
      bin_sh = {bcd_r[0], bin_r[WOUT-1:1]};
      bcd_nx = bcd_sh;
      for (int i = 0; i < NDIG; i++) begin
         if (bcd_sh[4*i+3])
            bcd_nx[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         bin_out   <= '0;
         err       <= 1'b0;
         busy      <= 1'b0;
         bcd_r     <= '0;
         bin_r     <= '0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  bin_r    <= '0;
                  cnt      <= '0;
                  if (bad_digit) begin
                     bcd_r     <= '0;
                     err       <= 1'b1;
                     bin_out   <= '0;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     bcd_r <= bcd_in;
                     state <= SHIFT;
                  end
               end
            end

            SHIFT: begin
               bcd_r <= bcd_nx;
               bin_r <= bin_sh;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST) begin
                  bin_out   <= bin_sh;
                  err       <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end

            DONE: begin
               // Result outputs are left untouched so they persist after the handshake.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
- Sequential BCD-to-binary converter; the inverse of the lab's binary-to-BCD/7-segment display path.
- Accepts a packed multi-digit BCD word, for example a switch-entered two-digit value such as "19".
- Converts it to an unsigned binary value using iterative reverse double-dabble: shift right, then subtract 3 from any digit that is 8 or more.
- Uses valid/ready handshakes on both sides and flags digits greater than 9, mirroring the team's >9 comparator checks.

Parameters:
NDIG, 2, number of BCD digits in bcd_in
WOUT, 7, binary output width; must satisfy 2^WOUT > 10^NDIG - 1 (7 covers 0..99)

Ports:
Clock  input  1  single clock, rising edge
Resetn  input  1  asynchronous, active-low reset
in_valid  input  1  bcd_in holds a word to convert
in_ready  output  1  block can accept a word (high only in IDLE)
bcd_in  input  4*NDIG  packed BCD; digit 0 (ones) in bits [3:0]
out_valid  output  1  bin_out/err hold a result
out_ready  input  1  consumer accepts the result
bin_out  output  WOUT  converted binary value
err  output  1  some input digit was > 9; bin_out forced to 0
busy  output  1  high in SHIFT and DONE

Behaviour:
- Reset (Resetn=0, asynchronous, any state including mid-conversion):
  - state=IDLE, in_ready=1, out_valid=0, bin_out=0, err=0, busy=0.
  - Internal registers cleared; any partial result is discarded.
- Internal state: shift register {bcd_r[4*NDIG-1:0], bin_r[WOUT-1:0]}, iteration counter cnt of width ceil(log2(WOUT+1)).
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready the word is captured and checked: a digit d is invalid iff d[3] & (d[2] | d[1]).
  - Any invalid digit: set err_r=1, bin_r=0, go to DONE (no shifting).
  - All digits valid: bcd_r=bcd_in, bin_r=0, cnt=0, err_r=0, go to SHIFT.
- SHIFT, one iteration per cycle:
  - Shift the concatenated register right by 1; the LSB of bcd_r enters the MSB of bin_r.
  - Then, for each post-shift digit of bcd_r that is >= 8, subtract 3 (4-bit, no borrow between digits).
  - Both steps are combinational and applied in the same cycle.
  - cnt increments; after the WOUT-th iteration go to DONE.
- DONE:
  - out_valid=1; bin_out=bin_r; err=err_r.
  - Outputs stay stable while out_ready=0; backpressure is held indefinitely.
  - On out_valid & out_ready, return to IDLE and deassert out_valid next cycle.
  - bin_out/err keep their last values after the handshake until the next result.
- Latency, accept cycle = 0:
  - Valid input: out_valid rises at cycle WOUT+1 (8 for defaults).
  - Error input: out_valid rises at cycle 1.
- Throughput: in_ready is low from acceptance until the output handshake completes, so there is one conversion in flight. Next accept is the cycle after the output handshake at the earliest.
- in_valid while busy is ignored; bcd_in need not stay stable after acceptance.
- Arithmetic: the result is exact for all valid inputs (max 10^NDIG - 1). Overflow cannot occur when the WOUT constraint holds. Non-compliant parameter pairs are a static configuration error; no runtime check.
- Simultaneous out_ready in the same cycle out_valid rises is legal: one-cycle DONE.

Test Plan:
- Reset, then bcd_in=8'h19, in_valid pulse, out_ready=1 -> out_valid at cycle 8, bin_out=7'd19, err=0, in_ready high the cycle after the handshake.
- Sweep all 100 valid BCD words 00..99 with out_ready=1 -> bin_out equals the decimal value each time; err=0; busy low only in IDLE.
- bcd_in=8'h1A, then 8'hC3 -> out_valid at cycle 1, err=1, bin_out=0; no SHIFT cycles observed.
- bcd_in=8'h99 with out_ready held low 5 cycles after out_valid -> bin_out=7'd99 stable, in_ready=0 throughout; a new in_valid in this window is ignored; releasing out_ready completes the handshake and returns to IDLE.
- Accept 8'h57 and assert Resetn=0 at SHIFT iteration 3 -> all outputs return to reset values asynchronously; after release, 8'h42 converts to 7'd42 with no residue.
- Back-to-back 8'h00 then 8'h01 with in_valid held high -> results 0 then 1, second accepted exactly one cycle after the first output handshake.
